// File: rtl/mips_reg_trace_if.sv
// Event stream from mips_reg_trace to a debug/logging consumer.
// First-word-fall-through head with a valid/ready handshake.
interface mips_reg_trace_if #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned TS_W   = 16
);
  logic              ev_valid;
  logic              ev_ready;
  logic [IDX_W-1:0]  ev_index;
  logic [DATA_W-1:0] ev_value;
  logic [PC_W-1:0]   ev_pc;
  logic [TS_W-1:0]   ev_time;

  modport master (
    output ev_valid, ev_index, ev_value, ev_pc, ev_time,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_index, ev_value, ev_pc, ev_time,
    output ev_ready
  );
endinterface

// File: rtl/mips_reg_trace.sv
// Register-change tracer: diffs the register file against a shadow copy and
// queues one {index, value, pc, time} event per change into a FWFT FIFO.
module mips_reg_trace #(
  parameter int unsigned         NUM_REGS   = 32,
  parameter int unsigned         DATA_W     = 32,
  parameter int unsigned         PC_W       = 32,
  parameter int unsigned         FIFO_DEPTH = 8,
  parameter int unsigned         TS_W       = 16,
  parameter logic [NUM_REGS-1:0] TRACE_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0},
  parameter int unsigned         IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [PC_W-1:0]            pc_in,
  mips_reg_trace_if.master           ev,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                coalesce_count
);

  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [NUM_REGS*DATA_W-1:0] shadow;
  logic [NUM_REGS-1:0]        pending;
  logic [NUM_REGS-1:0]        changed;
  logic [NUM_REGS-1:0]        cand;
  logic [NUM_REGS-1:0]        push_mask;
  logic [IDX_W-1:0]           sel;
  logic [DATA_W-1:0]          sel_val;
  logic                       sel_found;
  logic                       push;
  logic                       pop;
  logic                       coal_hit;
  logic [TS_W-1:0]            ts;

  logic [IDX_W-1:0]  idx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] val_mem [FIFO_DEPTH];
  logic [PC_W-1:0]   pc_mem  [FIFO_DEPTH];
  logic [TS_W-1:0]   ts_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  always_comb begin
    changed = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      changed[i] = enable & TRACE_MASK[i] &
                   (regs_flat[i*DATA_W +: DATA_W] != shadow[i*DATA_W +: DATA_W]);
    end
  end

  assign cand = pending | changed;

  // Lowest-index priority pick over pending and fresh changes.
  always_comb begin
    sel       = '0;
    sel_val   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (cand[i] && !sel_found) begin
        sel       = IDX_W'(i);
        sel_val   = regs_flat[i*DATA_W +: DATA_W];
        sel_found = 1'b1;
      end
    end
  end

  // Fullness is judged before this edge's pop, so a full FIFO never pushes.
  assign push = sel_found && (count < DEPTH_C);
  assign pop  = (count != '0) && ev.ev_ready;

  always_comb begin
    push_mask = '0;
    if (push) push_mask[sel] = 1'b1;
  end

  assign coal_hit = |(changed & pending & ~push_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow         <= regs_flat;
      pending        <= '0;
      ts             <= '0;
      coalesce_count <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      shadow  <= regs_flat;
      pending <= cand & ~push_mask;
      ts      <= ts + 1'b1;
      if (coal_hit && (coalesce_count != '1)) coalesce_count <= coalesce_count + 16'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr] <= sel;
      val_mem[wr_ptr] <= sel_val;
      pc_mem[wr_ptr]  <= pc_in;
      ts_mem[wr_ptr]  <= ts;
    end
  end

  assign ev.ev_valid = (count != '0);
  assign ev.ev_index = ev.ev_valid ? idx_mem[rd_ptr] : '0;
  assign ev.ev_value = ev.ev_valid ? val_mem[rd_ptr] : '0;
  assign ev.ev_pc    = ev.ev_valid ? pc_mem[rd_ptr]  : '0;
  assign ev.ev_time  = ev.ev_valid ? ts_mem[rd_ptr]  : '0;
  assign fifo_count  = count;

endmodule

// File: tb/tb_mips_reg_trace.sv
// Scoreboard bench for mips_reg_trace: directed register changes push expected
// events; a negedge monitor compares every popped event against the queue.
module tb_mips_reg_trace;
  localparam int unsigned NR = 32, DW = 32, PW = 32, TSW = 4, DEPTH = 8, IW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [NR*DW-1:0] regs_flat;
  logic [PW-1:0]   pc_in;
  logic [3:0]      fifo_count;
  logic [15:0]     coalesce_count;
  logic [TSW-1:0]  tb_ts;

  mips_reg_trace_if #(.IDX_W(IW), .DATA_W(DW), .PC_W(PW), .TS_W(TSW)) evif ();

  mips_reg_trace #(
    .NUM_REGS(NR), .DATA_W(DW), .PC_W(PW), .FIFO_DEPTH(DEPTH), .TS_W(TSW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .regs_flat(regs_flat),
    .pc_in(pc_in), .ev(evif), .fifo_count(fifo_count),
    .coalesce_count(coalesce_count)
  );

  always #5 clk = ~clk;

  // Timestamp the DUT should be holding between edges.
  always @(posedge clk) tb_ts <= reset ? 4'd0 : tb_ts + 4'd1;

  typedef struct packed {
    logic [IW-1:0]  idx;
    logic [DW-1:0]  val;
    logic [PW-1:0]  pc;
    logic [TSW-1:0] t;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setr(input int i, input logic [DW-1:0] v);
    regs_flat[i*DW +: DW] = v;
  endtask

  task automatic expect_ev(input int i, input logic [DW-1:0] v, input logic [PW-1:0] pc,
                           input logic [TSW-1:0] t);
    ev_t e;
    e.idx = IW'(i);
    e.val = v;
    e.pc  = pc;
    e.t   = t;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (reset === 1'b0 && evif.ev_valid === 1'b1 && evif.ev_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_event: got idx %0d value 0x%0h, required no event",
                 evif.ev_index, evif.ev_value);
      end else begin
        e = exp_q.pop_front();
        check("ev_index", 64'(evif.ev_index), 64'(e.idx));
        check("ev_value", 64'(evif.ev_value), 64'(e.val));
        check("ev_pc",    64'(evif.ev_pc),    64'(e.pc));
        check("ev_time",  64'(evif.ev_time),  64'(e.t));
      end
    end
  end

  initial begin
    logic [TSW-1:0] t;
    reset         = 1'b1;
    enable        = 1'b1;
    regs_flat     = '0;
    pc_in         = '0;
    evif.ev_ready = 1'b0;
    step();
    step();
    check("rst_valid", 64'(evif.ev_valid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_coal",  64'(coalesce_count), 64'd0);
    check("rst_index", 64'(evif.ev_index), 64'd0);
    check("rst_value", 64'(evif.ev_value), 64'd0);
    check("rst_pc",    64'(evif.ev_pc), 64'd0);
    check("rst_time",  64'(evif.ev_time), 64'd0);
    reset = 1'b0;

    // Single change, one cycle to visibility
    setr(8, 32'd5);
    pc_in = 32'h40;
    expect_ev(8, 32'd5, 32'h40, tb_ts);
    step();
    check("single_valid", 64'(evif.ev_valid), 64'd1);
    check("single_count", 64'(fifo_count), 64'd1);
    check("single_index", 64'(evif.ev_index), 64'd8);
    evif.ev_ready = 1'b1;
    step();
    check("single_drained", 64'(evif.ev_valid), 64'd0);

    // Three simultaneous changes drain lowest index first
    pc_in = 32'h44;
    t = tb_ts;
    setr(3, 32'd1); setr(9, 32'd2); setr(31, 32'd3);
    expect_ev(3, 32'd1, 32'h44, t);
    expect_ev(9, 32'd2, 32'h44, t + 4'd1);
    expect_ev(31, 32'd3, 32'h44, t + 4'd2);
    repeat (4) step();
    check("simul_drained", 64'(evif.ev_valid), 64'd0);

    // Backpressure fills the FIFO; R10 coalesces while pending
    evif.ev_ready = 1'b0;
    pc_in = 32'h80;
    t = tb_ts;
    for (int k = 1; k <= 8; k++) begin
      setr(k, 32'(100 + k));
      expect_ev(k, 32'(100 + k), 32'h80, t + 4'(k - 1));
    end
    step();
    setr(10, 32'd7);
    step();
    setr(10, 32'd9);
    step();
    repeat (5) step();
    check("bp_count",  64'(fifo_count), 64'd8);
    check("bp_coal",   64'(coalesce_count), 64'd1);
    check("bp_head_i", 64'(evif.ev_index), 64'd1);
    check("bp_head_v", 64'(evif.ev_value), 64'd101);
    evif.ev_ready = 1'b1;
    // Full at release: first edge only pops, R10 pushes on the next
    expect_ev(10, 32'd9, 32'h80, tb_ts + 4'd1);
    repeat (12) step();
    check("bp_drained", 64'(evif.ev_valid), 64'd0);

    // Masked R0 and disabled-period change are never reported
    setr(0, 32'h55);
    step(); step();
    check("mask_r0_valid", 64'(evif.ev_valid), 64'd0);
    enable = 1'b0;
    setr(4, 32'd6);
    step(); step();
    enable = 1'b1;
    step(); step();
    check("enable_valid", 64'(evif.ev_valid), 64'd0);
    check("enable_count", 64'(fifo_count), 64'd0);
    setr(4, 32'd7);
    expect_ev(4, 32'd7, 32'h80, tb_ts);
    step(); step();
    check("enable_drained", 64'(evif.ev_valid), 64'd0);

    // Reset with 5 queued and 3 pending discards everything
    evif.ev_ready = 1'b0;
    for (int k = 11; k <= 18; k++) setr(k, 32'(32'h300 + k));
    repeat (5) step();
    check("mid_count", 64'(fifo_count), 64'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", 64'(evif.ev_valid), 64'd0);
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    check("mid_rst_coal",  64'(coalesce_count), 64'd0);
    check("mid_rst_index", 64'(evif.ev_index), 64'd0);
    evif.ev_ready = 1'b1;
    repeat (6) step();
    check("mid_after_valid", 64'(evif.ev_valid), 64'd0);

    // 20 back-to-back changes: timestamp and pointer wrap
    for (int k = 0; k < 20; k++) begin
      setr(k + 1, 32'(32'h200 + k));
      pc_in = 32'(32'h100 + 4 * k);
      expect_ev(k + 1, 32'(32'h200 + k), 32'(32'h100 + 4 * k), tb_ts);
      step();
    end
    step(); step();
    check("wrap_drained", 64'(evif.ev_valid), 64'd0);

    // Push and pop together at DEPTH-1 keeps the count
    evif.ev_ready = 1'b0;
    pc_in = 32'h400;
    t = tb_ts;
    for (int k = 0; k < 7; k++) begin
      setr(21 + k, 32'(32'h500 + k));
      expect_ev(21 + k, 32'(32'h500 + k), 32'h400, t + 4'(k));
    end
    repeat (7) step();
    check("pp_count_before", 64'(fifo_count), 64'd7);
    setr(28, 32'h528);
    expect_ev(28, 32'h528, 32'h400, tb_ts);
    evif.ev_ready = 1'b1;
    step();
    check("pp_count_after", 64'(fifo_count), 64'd7);
    repeat (10) step();
    check("final_valid", 64'(evif.ev_valid), 64'd0);
    check("final_count", 64'(fifo_count), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_reg_trace.md
# mips_reg_trace

Parametrised, synthesizable register-change tracer for the MIPS core. It watches the flattened register-file bus, detects every register whose value changes, and queues one event per change into an internal FIFO. Each event carries the register index, its new value, the PC and a cycle timestamp. A debug/logging consumer drains events over a valid/ready handshake. The block is the hardware successor to simulation-only register monitoring: it runs at speed, works on any register count and width, and never silently drops a change.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers watched
- DATA_W, 32, register width; register i occupies regs_flat[i*DATA_W +: DATA_W]
- PC_W, 32, PC width
- FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2
- TS_W, 16, timestamp counter width
- TRACE_MASK, {NUM_REGS{1'b1}} with bit 0 cleared, per-register trace enable; bit i=1 traces register i
- IDX_W, $clog2(NUM_REGS), derived index width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  detection enable
- regs_flat  in  NUM_REGS*DATA_W  flattened register file contents
- pc_in  in  PC_W  current PC of the core
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head this cycle
- ev_index  out  IDX_W  register index of the head event
- ev_value  out  DATA_W  register value of the head event
- ev_pc  out  PC_W  PC of the head event
- ev_time  out  TS_W  timestamp of the head event
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
- coalesce_count  out  16  number of coalesced changes, saturating

## Operation
- State: shadow copy of regs_flat, pending mask[NUM_REGS], FIFO, ts counter, coalesce_count.
- **Reset** (reset=1 at an edge):
  - shadow <= regs_flat; pending, FIFO, ts and coalesce_count <= 0.
  - Outputs after reset: ev_valid=0, fifo_count=0, coalesce_count=0; ev_index, ev_value, ev_pc and ev_time =0.
  - If reset asserts mid-operation, all queued and pending events are discarded.
- **Change detection** (every edge, reset=0):
  - changed[i] = enable & TRACE_MASK[i] & (regs_flat slice i != shadow slice i).
  - Shadow always reloads from regs_flat, including when enable=0. Changes that occur while enable=0 are intentionally not traced.
- **Push selection:**
  - sel = lowest index set in (pending | changed).
  - Push happens when that set is non-empty and fifo_count < FIFO_DEPTH, evaluated before this edge's pop. A full FIFO does not push, even if a pop occurs in the same cycle.
  - The pushed entry is {sel, regs_flat slice sel, pc_in, ts}, all sampled at this edge.
- **Pending update:** pending <= (pending | changed) & ~(push ? onehot(sel) : 0).
- **Coalescing:**
  - If changed[i] & pending[i] & ~(push & sel==i), coalesce_count increments by 1, saturating at 0xFFFF. At most one increment per cycle: the count is incremented, not the number of such i.
  - The event later pushed for that register carries the latest value only.
- **FIFO:**
  - First-word-fall-through; the head drives the ev_* outputs.
  - Pop occurs on ev_valid & ev_ready.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **ts:** free-running, +1 every non-reset edge, wraps 2^TS_W-1 -> 0.
- No change is ever lost except by coalescing or by enable=0. Backpressure accumulates in the pending mask.

## Timing
- Change-to-visibility latency:
  - A register change presented before edge E with the FIFO empty and no other pending bits gives a push at E.
  - ev_valid=1 is visible after E, i.e. 1 cycle.
- Throughput: one event pushed per cycle maximum. N simultaneous changes drain over N consecutive edges, lowest index first.
- ev_* outputs are registered FIFO state and are stable while ev_valid=1 & ev_ready=0.
- ev_valid drops the edge after the last entry pops, unless a push occurs at that same edge.

## Test plan
- **Single change:** reset 2 cycles, then set R8 from 0 to 5 with pc_in=0x40 -> next cycle ev_valid=1, ev_index=8, ev_value=5, ev_pc=0x40, fifo_count=1; ev_ready=1 pops it and ev_valid=0.
- **Simultaneous changes:** R3=1, R9=2 and R31=3 in one cycle, ev_ready=1 -> events in order 3, 9, 31 on consecutive cycles with ev_time incrementing by 1.
- **Backpressure and coalescing:**
  - Setup: ev_ready=0, FIFO_DEPTH=8; change R1 through R8 once each, then R10 to 7, then R10 to 9 while R10 is still pending.
  - Expected: fifo_count=8, coalesce_count=1. Releasing ev_ready yields a single R10 event with value 9.
- **Masking and enable:**
  - Changing R0 never produces an event.
  - With enable=0, changing R4 to 6 produces nothing. With enable=1 afterwards and R4 unchanged, still nothing.
  - Changing R4 to 7 then yields one event with value 7.
- **Reset mid-operation:** with 5 events queued and 3 pending, assert reset for 1 cycle -> ev_valid=0, fifo_count=0, coalesce_count=0, no events follow.
- **Wrap-around:**
  - TS_W=4: run 20 cycles with one change every cycle, with ev_ready=1 every cycle. Expected: ev_time wraps 15 -> 0, and FIFO pointers wrap with no lost or duplicated events.
  - Separately, push and pop in the same cycle at fifo_count=FIFO_DEPTH-1 -> fifo_count stays FIFO_DEPTH-1.
